el2_trace_fifo: RTL and testbench



---
 rtl/el2_trace_fifo.sv | 161 ++++++++++++++++
 tb/tb_el2_trace_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/el2_trace_fifo.sv
// -----------------------------------------------------------------------------
// el2_trace_fifo
//
// Capture buffer for retirement trace packets (el2_trace_pkt_t, 104 bits).
// Each valid packet from the core is pushed into a DEPTH-entry FIFO and
// drained to an external trace sink over a valid/ready handshake. Overflow
// is reported three ways:
//   - a saturating drop counter;
//   - a sticky overflow flag;
//   - a "lost" tag on the first packet accepted after one or more drops.
//
// Packet layout (MSB first), matching el2_trace_pkt_t:
//   [103:72] trace_rv_i_insn_ip      [71:40] trace_rv_i_address_ip
//   [39]     trace_rv_i_valid_ip     [38]    trace_rv_i_exception_ip
//   [37:33]  trace_rv_i_ecause_ip    [32]    trace_rv_i_interrupt_ip
//   [31:0]   trace_rv_i_tval_ip
//
// Parameters:
//   DEPTH        number of FIFO entries, power of two, 2..64
//   CNTW         width of the occupancy count, $clog2(DEPTH)+1
// Ports:
//   clk          core clock
//   rst_l        asynchronous active-low reset
//   trace_en     capture enable; when low nothing is pushed (pops continue)
//   trace_clear  synchronous flush of entries, counters and flags
//   trace_in     packet from the core, pushed when its valid bit is set
//   trace_out    head-of-FIFO packet, zero when out_valid=0
//   out_lost     head entry follows one or more drops, zero when out_valid=0
//   out_valid    FIFO non-empty
//   out_ready    sink accepts the head this cycle
//   fifo_count   current occupancy, 0..DEPTH
//   ovf_cnt      number of dropped packets, saturating at 16'hFFFF
//   ovf_sticky   set on any drop, cleared by trace_clear or reset
// -----------------------------------------------------------------------------
module el2_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            trace_en,
  input  logic            trace_clear,
  input  logic [103:0]    trace_in,
  output logic [103:0]    trace_out,
  output logic            out_lost,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CNTW-1:0] fifo_count,
  output logic [15:0]     ovf_cnt,
  output logic            ovf_sticky
);

  localparam int PW        = $clog2(DEPTH);
  localparam int PKTW      = 104;
  localparam int VALID_BIT = 39;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  // Storage: packet plus its "first after a drop" tag.
  logic [PKTW-1:0] mem_pkt_r  [DEPTH];
  logic            mem_lost_r [DEPTH];

  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CNTW-1:0] count_r;
  logic [15:0]     ovf_cnt_r;
  logic            ovf_sticky_r;
  logic            lost_pend_r;

  logic            push_req_s;
  logic            out_valid_s;
  logic            pop_s;
  logic            full_s;
  logic            push_acc_s;
  logic            drop_s;
  logic [CNTW-1:0] count_nxt_s;
  logic [15:0]     ovf_sat_s;

  assign push_req_s  = trace_en & trace_in[VALID_BIT];
  assign out_valid_s = (count_r != {CNTW{1'b0}});
  assign pop_s       = out_valid_s & out_ready;
  assign full_s      = (count_r == FULL_CNT);
  // A full FIFO that is popping in the same cycle frees the slot being
  // written, so the push is accepted rather than dropped.
  assign push_acc_s  = push_req_s & (~full_s | pop_s);
  assign drop_s      = push_req_s & full_s & ~pop_s;

  // Next occupancy and saturating drop count.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_acc_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNTW'(1);
      2'b01:   count_nxt_s = count_r - CNTW'(1);
      default: count_nxt_s = count_r;
    endcase
    if (ovf_cnt_r == 16'hFFFF) begin
      ovf_sat_s = ovf_cnt_r;
    end else begin
      ovf_sat_s = ovf_cnt_r + 16'd1;
    end
  end

  // Pointers, occupancy, overflow counter and flags; trace_clear overrides push/pop.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CNTW{1'b0}};
      ovf_cnt_r    <= 16'd0;
      ovf_sticky_r <= 1'b0;
      lost_pend_r  <= 1'b0;
    end else if (trace_clear) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CNTW{1'b0}};
      ovf_cnt_r    <= 16'd0;
      ovf_sticky_r <= 1'b0;
      lost_pend_r  <= 1'b0;
    end else begin
      if (push_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_nxt_s;
      // Drop and accept are mutually exclusive, so lost_pend never sees both.
      if (drop_s) begin
        ovf_cnt_r    <= ovf_sat_s;
        ovf_sticky_r <= 1'b1;
        lost_pend_r  <= 1'b1;
      end else if (push_acc_s) begin
        lost_pend_r  <= 1'b0;
      end
    end
  end

  // Entry storage; left unreset because pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_acc_s && !trace_clear) begin
      mem_pkt_r[wr_ptr_r]  <= trace_in;
      mem_lost_r[wr_ptr_r] <= lost_pend_r;
    end
  end

  // Head-of-FIFO presentation, forced to zero while empty.
  always_comb begin
    if (out_valid_s) begin
      trace_out = mem_pkt_r[rd_ptr_r];
      out_lost  = mem_lost_r[rd_ptr_r];
    end else begin
      trace_out = {PKTW{1'b0}};
      out_lost  = 1'b0;
    end
  end

  assign out_valid  = out_valid_s;
  assign fifo_count = count_r;
  assign ovf_cnt    = ovf_cnt_r;
  assign ovf_sticky = ovf_sticky_r;

endmodule

// File: tb/tb_el2_trace_fifo.sv
module tb_el2_trace_fifo;

  localparam int DEPTH = 8;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_l = 1'b0;
  logic            trace_en = 1'b0;
  logic            trace_clear = 1'b0;
  logic            out_ready = 1'b0;
  logic [103:0]    trace_in = 104'd0;
  logic [103:0]    trace_out;
  logic            out_lost;
  logic            out_valid;
  logic [CNTW-1:0] fifo_count;
  logic [15:0]     ovf_cnt;
  logic            ovf_sticky;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  el2_trace_fifo #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .trace_en   (trace_en),
    .trace_clear(trace_clear),
    .trace_in   (trace_in),
    .trace_out  (trace_out),
    .out_lost   (out_lost),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .ovf_cnt    (ovf_cnt),
    .ovf_sticky (ovf_sticky)
  );

  // Scoreboard of expected head entries plus reference state.
  typedef struct packed {
    logic        lost;
    logic [31:0] insn;
  } exp_t;
  exp_t exp_q[$];
  int   m_count;
  int   m_ovf;
  logic m_sticky;
  logic m_lost_pend;

  // Table of vectors: inputs and expected post-edge state.
  typedef struct {
    logic        en, vld, clr, rdy;
    logic [31:0] insn;
    int          cnt;
    int          ovf;
    logic        sticky;
  } vec_t;
  vec_t vecs[32];
  int   nvec = 0;

  function automatic logic [103:0] mk_pkt(input logic [31:0] insn, input logic vld);
    mk_pkt = {insn, insn ^ 32'h8000_0000, vld, 1'b0, 5'd0, 1'b0, ~insn};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count     = 0;
    m_ovf       = 0;
    m_sticky    = 1'b0;
    m_lost_pend = 1'b0;
    exp_q.delete();
  endtask

  task automatic add_vec(input logic en, vld, clr, rdy, input logic [31:0] insn,
                         input int cnt, input int ovf, input logic sticky);
    vecs[nvec] = '{en, vld, clr, rdy, insn, cnt, ovf, sticky};
    nvec++;
  endtask

  // One clock cycle: drive at negedge, check head before the edge, check state after.
  task automatic drive(input logic en, vld, clr, rdy, input logic [31:0] insn);
    bit   pop, req, acc, drop;
    exp_t e;
    @(negedge clk);
    trace_en    = en;
    trace_in    = mk_pkt(insn, vld);
    trace_clear = clr;
    out_ready   = rdy;
    #1;
    chk("out_valid", 64'(out_valid), (m_count != 0) ? 64'd1 : 64'd0);
    if (m_count != 0) begin
      e = exp_q[0];
      chk("head_insn", 64'(trace_out[103:72]), 64'(e.insn));
      chk("head_tval", 64'(trace_out[31:0] ^ e.insn), 64'hFFFF_FFFF);
      chk("head_lost", 64'(out_lost), 64'(e.lost));
    end else begin
      chk("empty_out_zero", (trace_out === 104'd0) ? 64'd1 : 64'd0, 64'd1);
      chk("empty_lost_zero", 64'(out_lost), 64'd0);
    end
    pop = (m_count != 0) && rdy;
    req = en && vld;
    if (clr) begin
      model_reset();
    end else begin
      if (pop) void'(exp_q.pop_front());
      acc  = req && ((m_count < DEPTH) || pop);
      drop = req && (m_count == DEPTH) && !pop;
      if (acc) begin
        e.lost = m_lost_pend;
        e.insn = insn;
        exp_q.push_back(e);
        m_lost_pend = 1'b0;
      end
      if (drop) begin
        if (m_ovf < 65535) m_ovf++;
        m_sticky    = 1'b1;
        m_lost_pend = 1'b1;
      end
      m_count = m_count + (acc ? 1 : 0) - (pop ? 1 : 0);
    end
    @(posedge clk);
    #1;
    chk("fifo_count", 64'(fifo_count), 64'(m_count));
    chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
    chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic ordering: insn 1..5 with the sink always ready.
    for (int i = 1; i <= 5; i++) add_vec(1'b1, 1'b1, 1'b0, 1'b1, 32'(i), 1, 0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 0, 0, 1'b0);
    // Fill and overflow: ten pushes into an 8-deep FIFO with the sink stalled.
    for (int i = 0; i < 10; i++)
      add_vec(1'b1, 1'b1, 1'b0, 1'b0, 32'h11 + 32'(i), (i < 8) ? i + 1 : 8,
              (i >= 8) ? i - 7 : 0, (i >= 8) ? 1'b1 : 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 7, 2, 1'b1);
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, 32'hAA, 8, 2, 1'b1);
    for (int i = 0; i < 8; i++) add_vec(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 7 - i, 2, 1'b1);

    model_reset();
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_trace_out", (trace_out === 104'd0) ? 64'd1 : 64'd0, 64'd1);
    chk("rst_out_lost", 64'(out_lost), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
    chk("rst_ovf_sticky", 64'(ovf_sticky), 64'd0);
    @(negedge clk);
    rst_l = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].en, vecs[i].vld, vecs[i].clr, vecs[i].rdy, vecs[i].insn);
      chk("vec_count", 64'(fifo_count), 64'(vecs[i].cnt));
      chk("vec_ovf", 64'(ovf_cnt), 64'(vecs[i].ovf));
      chk("vec_sticky", 64'(ovf_sticky), 64'(vecs[i].sticky));
    end

    // Full FIFO with simultaneous push and pop: accepted, not a drop.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h30 + 32'(i));
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
    chk("full_pp_count", 64'(fifo_count), 64'd8);
    chk("full_pp_ovf", 64'(ovf_cnt), 64'd2);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    chk("full_pp_drained", 64'(out_valid), 64'd0);

    // Clear priority over a simultaneous push and pop.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h60 + 32'(i));
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h70 + 32'(i));
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    chk("pre_clr_count", 64'(fifo_count), 64'd3);
    chk("pre_clr_ovf", 64'(ovf_cnt), 64'd5);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h77);
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_count", 64'(fifo_count), 64'd0);
    chk("clr_ovf", 64'(ovf_cnt), 64'd0);
    chk("clr_sticky", 64'(ovf_sticky), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("clr_pkt_absent", 64'(out_valid), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h78);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);

    // Capture disabled: valid packets are ignored, never counted as drops.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h80 + 32'(i));
    chk("en_off_count", 64'(fifo_count), 64'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h90 + 32'(i));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hA0 + 32'(i));
    chk("en_off_ovf", 64'(ovf_cnt), 64'd0);
    chk("en_off_sticky", 64'(ovf_sticky), 64'd0);

    // Saturation of the drop counter.
    for (int i = 0; i < 65540; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'(i));
    chk("sat_ovf", 64'(ovf_cnt), 64'hFFFF);
    chk("sat_count", 64'(fifo_count), 64'd8);

    // Asynchronous reset between edges with four entries held.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h50 + 32'(i));
    chk("pre_rst_count", 64'(fifo_count), 64'd4);
    @(negedge clk);
    trace_en    = 1'b0;
    trace_in    = 104'd0;
    trace_clear = 1'b0;
    out_ready   = 1'b0;
    #2;
    rst_l = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_trace_out", (trace_out === 104'd0) ? 64'd1 : 64'd0, 64'd1);
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h99);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_insn", 64'(trace_out[103:72]), 64'h99);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
